eth_ddr3_wr_packer: RTL and testbench
=====================================

ETH_DDR3_WR_PACKER -- requirements
Module: eth_ddr3_wr_packer

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 4: width in clk cycles of the wr_load pulse issued at frame start (legal 1..255).
REQ-002 SHALL have parameter BYTE_ORDER, default 0: 0 = first byte of a pair in wfifo_din[15:8]; 1 = first byte in wfifo_din[7:0].
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; equals the write-FIFO write clock (wr_clk) of the DDR3 two-port controller.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 s_data  in  8  payload byte.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_last  in  1  final byte of the frame, qualified by s_valid.
REQ-009 s_ready  out  1  byte accepted when s_valid && s_ready.
REQ-010 init_calib_complete  in  1  DDR3 calibration done.
REQ-011 wrfifo_full  in  1  controller write FIFO full.
REQ-012 wfifo_wren  out  1  write strobe to controller write FIFO.
REQ-013 wfifo_din  out  16  packed word to controller write FIFO.
REQ-014 wr_load  out  1  write-address reload pulse to controller.
REQ-015 frame_done  out  1  one-cycle pulse after last word written.
REQ-016 frame_words  out  16  words written in last completed frame.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, LOAD, RECV, DONE.
REQ-019 IDLE: s_ready=0; go to LOAD when s_valid=1 && init_calib_complete=1; init_calib_complete is sampled only in IDLE.
REQ-020 LOAD: wr_load=1 (registered) for exactly LOAD_CYCLES cycles, s_ready=0, word counter and half-word holder cleared; then RECV.
REQ-021 RECV: s_ready = !wrfifo_full (combinational); wr_load=0.
REQ-022 Accepted byte with holder empty and s_last=0: byte stored in holder, no write.
REQ-023 Accepted byte with holder full: same cycle wfifo_wren=1, wfifo_din = {holder, s_data} (BYTE_ORDER=0) or {s_data, holder} (BYTE_ORDER=1), holder emptied.
REQ-024 Accepted byte with holder empty and s_last=1: same cycle wfifo_wren=1, wfifo_din = {s_data, 8'h00} (BYTE_ORDER=0) or {8'h00, s_data} (BYTE_ORDER=1).
REQ-025 wfifo_wren and wfifo_din are combinational from the accept; wfifo_wren=1 only when wrfifo_full=0; wfifo_din=16'h0000 when wfifo_wren=0.
REQ-026 Any accepted byte with s_last=1: go to DONE next cycle.
REQ-027 Word counter increments by 1 per wfifo_wren; 16-bit, saturates at 16'hFFFF (no wrap).
REQ-028 DONE: frame_done=1 for one cycle, frame_words loaded with word counter (including pad word), s_ready=0; then IDLE.
REQ-029 frame_words holds its value until the next DONE or reset.
REQ-030 wrfifo_full asserting mid-frame SHALL stall acceptance without losing the holder byte; no timeout.
REQ-031 s_valid=0 mid-frame SHALL leave state and holder unchanged.
REQ-032 Zero-length frames are impossible; an s_last byte is always at least one accepted byte.

Reset
REQ-033 On rst=1, regardless of state: state=IDLE, s_ready=0, wfifo_wren=0, wfifo_din=0, wr_load=0, frame_done=0, frame_words=0, busy=0, holder and counters cleared; a partial frame is discarded with no pad write.
REQ-034 After rst deasserts, the first frame starts only via IDLE->LOAD per REQ-019.

Verification
REQ-035 init=1, frame 11 22 33 44 (last on 44), full=0 -> wr_load high 4 cycles, writes 16'h1122 then 16'h3344, frame_done pulse, frame_words=2.
REQ-036 Odd frame AA BB CC -> writes 16'hAABB, 16'hCC00; frame_words=2.
REQ-037 wrfifo_full=1 for 5 cycles after byte 33 held in frame 11 22 33 44 -> s_ready=0 and wfifo_wren=0 throughout; after release writes 16'h3344; no byte lost or duplicated.
REQ-038 BYTE_ORDER=1, frame 11 22 33 -> writes 16'h2211, 16'h0033.
REQ-039 s_valid=1, init=0 for 10 cycles -> busy=0, wr_load=0, s_ready=0; init rises -> LOAD entered next cycle.
REQ-040 rst pulsed after byte 55 (holder full) in a frame -> all outputs 0 at once, no write of 55; next frame 66 77 (last) -> single write 16'h6677, frame_words=1.

Source files
------------

// File: rtl/eth_ddr3_wr_packer.sv
// Packs an 8-bit byte stream into 16-bit words for the DDR3 controller
// write FIFO, framing each packet with a wr_load reload pulse.
module eth_ddr3_wr_packer #(
   parameter int LOAD_CYCLES = 4,
   parameter int BYTE_ORDER  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        init_calib_complete,
   input  logic        wrfifo_full,
   output logic        wfifo_wren,
   output logic [15:0] wfifo_din,
   output logic        wr_load,
   output logic        frame_done,
   output logic [15:0] frame_words,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LOAD, RECV, DONE} state_t;

   localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYCLES - 1);

   state_t      state;
   state_t      state_nx;
   logic [7:0]  load_cnt;
   logic [7:0]  holder;
   logic        holder_vld;
   logic [15:0] word_cnt;
   logic [15:0] word_cnt_nx;
   logic        accept;
   logic        wr;
   logic        wr_load_q;
   logic        frame_done_q;

   assign s_ready = (state == RECV) && !wrfifo_full;
   assign accept  = s_ready && s_valid;
   // A word goes out when the pair completes or the frame ends odd.
   assign wr      = accept && (holder_vld || s_last);

   assign wfifo_wren = wr;
   assign wr_load    = wr_load_q;
   assign frame_done = frame_done_q;
   assign busy       = (state != IDLE);

   always_comb begin
      wfifo_din = 16'h0000;
      if (wr) begin
         if (holder_vld)
            wfifo_din = (BYTE_ORDER == 0) ? {holder, s_data}
                                          : {s_data, holder};
         else
            wfifo_din = (BYTE_ORDER == 0) ? {s_data, 8'h00}
                                          : {8'h00, s_data};
      end
   end

   always_comb begin
      word_cnt_nx = word_cnt;
      if (wr && (word_cnt != 16'hFFFF))
         word_cnt_nx = word_cnt + 16'd1;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (s_valid && init_calib_complete) state_nx = LOAD;
         LOAD: if (load_cnt == LOAD_LAST) state_nx = RECV;
         RECV: if (accept && s_last) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         load_cnt     <= 8'd0;
         holder       <= 8'd0;
         holder_vld   <= 1'b0;
         word_cnt     <= 16'd0;
         frame_words  <= 16'd0;
         wr_load_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state        <= state_nx;
         wr_load_q    <= (state_nx == LOAD);
         frame_done_q <= (state_nx == DONE);
         if (state == IDLE)
            load_cnt <= 8'd0;
         else if (state == LOAD)
            load_cnt <= load_cnt + 8'd1;
         if (state == LOAD) begin
            holder     <= 8'd0;
            holder_vld <= 1'b0;
            word_cnt   <= 16'd0;
         end else begin
            word_cnt <= word_cnt_nx;
            if (accept) begin
               if (wr) begin
                  holder_vld <= 1'b0;
               end else begin
                  holder     <= s_data;
                  holder_vld <= 1'b1;
               end
            end
         end
         // Count is captured as the frame closes so it is valid during DONE.
         if ((state == RECV) && (state_nx == DONE))
            frame_words <= word_cnt_nx;
      end
   end

endmodule

// File: tb/tb_eth_ddr3_wr_packer.sv
// Table-driven bench for eth_ddr3_wr_packer, one instance per byte order
// sharing stimulus, plus a hand-written frame timing sequence.
module tb_eth_ddr3_wr_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        init = 1'b0;
   logic        full = 1'b0;

   logic        rdy0, wren0, wrl0, done0, busy0;
   logic [15:0] din0, fw0;
   logic        rdy1, wren1, wrl1, done1, busy1;
   logic [15:0] din1, fw1;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   eth_ddr3_wr_packer #(.LOAD_CYCLES(4), .BYTE_ORDER(0)) dut0 (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(rdy0),
      .init_calib_complete(init), .wrfifo_full(full),
      .wfifo_wren(wren0), .wfifo_din(din0),
      .wr_load(wrl0), .frame_done(done0),
      .frame_words(fw0), .busy(busy0)
   );

   eth_ddr3_wr_packer #(.LOAD_CYCLES(4), .BYTE_ORDER(1)) dut1 (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(rdy1),
      .init_calib_complete(init), .wrfifo_full(full),
      .wfifo_wren(wren1), .wfifo_din(din1),
      .wr_load(wrl1), .frame_done(done1),
      .frame_words(fw1), .busy(busy1)
   );

   typedef struct {
      logic        r;
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        i;
      logic        f;
      logic        rdy;
      logic        wr;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        wl;
      logic        dn;
      logic        bs;
      logic [15:0] fw;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int r,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      total++;
      if (got === exp)
         passed++;
      else
         $display("FAIL %s row %0d: got %h want %h", nm, r, got, exp);
   endtask

   task automatic row(input logic r, input logic v,
                      input logic [7:0] d, input logic l,
                      input logic i, input logic f,
                      input logic rdy, input logic wr,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic wl, input logic dn,
                      input logic bs, input logic [15:0] fw);
      vec_t e;
      e.r = r; e.v = v; e.d = d; e.l = l; e.i = i; e.f = f;
      e.rdy = rdy; e.wr = wr; e.d0 = d0; e.d1 = d1;
      e.wl = wl; e.dn = dn; e.bs = bs; e.fw = fw;
      tbl.push_back(e);
   endtask

   task automatic idle(input logic v, input logic [7:0] d,
                       input logic i, input logic [15:0] fw);
      row(0, v, d, 0, i, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, fw);
   endtask

   task automatic start(input logic [7:0] d, input logic [15:0] fw);
      idle(1, d, 1, fw);
      for (int k = 0; k < 4; k++)
         row(0, 1, d, 0, 1, 0, 0, 0, 16'h0, 16'h0, 1, 0, 1, fw);
   endtask

   task automatic recv(input logic v, input logic [7:0] d,
                       input logic l, input logic i, input logic f,
                       input logic wr, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [15:0] fw);
      row(0, v, d, l, i, f, !f, wr, d0, d1, 0, 0, 1, fw);
   endtask

   task automatic done(input logic [15:0] fw);
      row(0, 0, 8'h00, 0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 1, 1, fw);
   endtask

   initial begin
      int   nload;
      logic got_rdy;

      row(1, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
      for (int k = 0; k < 10; k++)
         idle(1, 8'h11, 0, 16'h0);
      // even frame
      start(8'h11, 16'h0);
      recv(1, 8'h11, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
      recv(1, 8'h22, 0, 1, 0, 1, 16'h1122, 16'h2211, 16'h0);
      recv(1, 8'h33, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
      recv(1, 8'h44, 1, 1, 0, 1, 16'h3344, 16'h4433, 16'h0);
      done(16'd2);
      idle(0, 8'h00, 1, 16'd2);
      // odd frame
      start(8'hAA, 16'd2);
      recv(1, 8'hAA, 0, 1, 0, 0, 16'h0, 16'h0, 16'd2);
      recv(1, 8'hBB, 0, 1, 0, 1, 16'hAABB, 16'hBBAA, 16'd2);
      recv(1, 8'hCC, 1, 1, 0, 1, 16'hCC00, 16'h00CC, 16'd2);
      done(16'd2);
      idle(0, 8'h00, 1, 16'd2);
      // odd frame, valid gap, init dropped outside IDLE
      start(8'h11, 16'd2);
      recv(1, 8'h11, 0, 0, 0, 0, 16'h0, 16'h0, 16'd2);
      recv(0, 8'h99, 0, 0, 0, 0, 16'h0, 16'h0, 16'd2);
      recv(1, 8'h22, 0, 0, 0, 1, 16'h1122, 16'h2211, 16'd2);
      recv(1, 8'h33, 1, 0, 0, 1, 16'h3300, 16'h0033, 16'd2);
      done(16'd2);
      idle(0, 8'h00, 1, 16'd2);
      // FIFO full stall with holder occupied
      start(8'h11, 16'd2);
      recv(1, 8'h11, 0, 1, 0, 0, 16'h0, 16'h0, 16'd2);
      recv(1, 8'h22, 0, 1, 0, 1, 16'h1122, 16'h2211, 16'd2);
      recv(1, 8'h33, 0, 1, 0, 0, 16'h0, 16'h0, 16'd2);
      for (int k = 0; k < 5; k++)
         recv(1, 8'h44, 1, 1, 1, 0, 16'h0, 16'h0, 16'd2);
      recv(1, 8'h44, 1, 1, 0, 1, 16'h3344, 16'h4433, 16'd2);
      done(16'd2);
      idle(0, 8'h00, 1, 16'd2);
      // reset with holder full, then a one-word frame
      start(8'h55, 16'd2);
      recv(1, 8'h55, 0, 1, 0, 0, 16'h0, 16'h0, 16'd2);
      row(1, 1, 8'h66, 0, 1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
      start(8'h66, 16'h0);
      recv(1, 8'h66, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
      recv(1, 8'h77, 1, 1, 0, 1, 16'h6677, 16'h7766, 16'h0);
      done(16'd1);
      idle(0, 8'h00, 1, 16'd1);

      for (int n = 0; n < tbl.size(); n++) begin
         @(negedge clk);
         rst     = tbl[n].r;
         s_valid = tbl[n].v;
         s_data  = tbl[n].d;
         s_last  = tbl[n].l;
         init    = tbl[n].i;
         full    = tbl[n].f;
         #1;
         chk("s_ready", n, 16'(rdy0), 16'(tbl[n].rdy));
         chk("wfifo_wren", n, 16'(wren0), 16'(tbl[n].wr));
         chk("wfifo_din", n, din0, tbl[n].d0);
         chk("wr_load", n, 16'(wrl0), 16'(tbl[n].wl));
         chk("frame_done", n, 16'(done0), 16'(tbl[n].dn));
         chk("busy", n, 16'(busy0), 16'(tbl[n].bs));
         chk("frame_words", n, fw0, tbl[n].fw);
         chk("bo1_s_ready", n, 16'(rdy1), 16'(tbl[n].rdy));
         chk("bo1_wren", n, 16'(wren1), 16'(tbl[n].wr));
         chk("bo1_din", n, din1, tbl[n].d1);
         chk("bo1_wr_load", n, 16'(wrl1), 16'(tbl[n].wl));
         chk("bo1_done", n, 16'(done1), 16'(tbl[n].dn));
         chk("bo1_busy", n, 16'(busy1), 16'(tbl[n].bs));
         chk("bo1_frame_words", n, fw1, tbl[n].fw);
      end

      // single-byte frame: count wr_load width, bounded wait for s_ready
      @(negedge clk);
      rst = 0; s_valid = 1; s_data = 8'h5A; s_last = 1;
      init = 1; full = 0;
      nload   = 0;
      got_rdy = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (rdy0) begin
            got_rdy = 1'b1;
            break;
         end
         if (wrl0) nload++;
      end
      chk("seq_ready_seen", 900, 16'(got_rdy), 16'd1);
      chk("seq_load_width", 901, 16'(nload), 16'd4);
      chk("seq_wren", 902, 16'(wren0), 16'd1);
      chk("seq_din", 903, din0, 16'h5A00);
      chk("seq_bo1_din", 904, din1, 16'h005A);
      @(posedge clk);
      #1;
      s_valid = 0; s_last = 0;
      chk("seq_done", 905, 16'(done0), 16'd1);
      chk("seq_words", 906, fw0, 16'd1);
      @(posedge clk);
      #1;
      chk("seq_done_end", 907, 16'(done0), 16'd0);
      chk("seq_busy_end", 908, 16'(busy0), 16'd0);
      chk("seq_words_hold", 909, fw0, 16'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
